// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, funct3 codes,
// branch condition and immediate-format enums, and the decoded-output record.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    BRANCH_NONE   = 3'd0,
    BRANCH_ALWAYS = 3'd1,
    BRANCH_EQ     = 3'd2,
    BRANCH_NE     = 3'd3,
    BRANCH_LT     = 3'd4,
    BRANCH_GE     = 3'd5,
    BRANCH_LTU    = 3'd6,
    BRANCH_GEU    = 3'd7
  } branch_cond_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  op1;
    logic [31:0]  op2;
    logic [2:0]   alu_op;
    logic         alu_sub;
    logic         shift_arith;
    logic         reg_write;
    logic [4:0]   rd;
    logic         ls_enable;
    logic         ls_write;
    logic [2:0]   ls_sel;
    logic [31:0]  ls_wdata;
    branch_cond_t cond;
    logic [31:0]  target;
  } decode_out_t;

endpackage

// File: rtl/decode_imm.sv
// Combinational extraction of the sign-extended I/S/B/U/J immediate
// selected by fmt_i. Opcode bits are not needed, so only [31:7] come in.
module decode_imm
  import decode_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_fmt_t    fmt_i,
  output logic [31:0] imm_o
);

  // Select and sign-extend the immediate for the requested format
  always_comb begin
    imm_o = '0;
    unique case (fmt_i)
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm_o = {instr_i[31:12], 12'h000};
      IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage with a single-entry output register and flush.
// Optional macro DECODE_ILLEGAL_INSTR_EN adds the illegal_instr_o flag;
// illegal encodings always decode as NOPs either way.
module decode
  import decode_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic        flush_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] alu_operand1_o,
  output logic [31:0] alu_operand2_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_sub_o,
  output logic        alu_shift_arith_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic        ls_enable_o,
  output logic        ls_write_o,
  output logic [2:0]  ls_sel_o,
  output logic [31:0] ls_write_data_o,
  output logic [2:0]  branch_cond_o,
  output logic [31:0] branch_target_o,
  output logic        output_valid_o,
  input  logic        output_ready_i
`ifdef DECODE_ILLEGAL_INSTR_EN
  ,
  output logic        illegal_instr_o
`endif
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  imm_fmt_t    fmt;
  logic [31:0] imm;
  logic [31:0] jalr_sum;
  logic        ill_d;
  logic        accept;
  logic        valid_q;
  decode_out_t out_d, out_q;

  assign opc      = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign f7       = instr_i[31:25];
  assign jalr_sum = rs1_data_i + imm;

  assign rs1_addr_o    = instr_i[19:15];
  assign rs2_addr_o    = instr_i[24:20];
  assign input_ready_o = !valid_q || output_ready_i;
  assign accept        = input_valid_i && input_ready_o && !flush_i;

  // Pick the immediate format implied by the opcode
  always_comb begin
    fmt = IMM_I;
    case (opc)
      OPC_LUI, OPC_AUIPC: fmt = IMM_U;
      OPC_JAL:            fmt = IMM_J;
      OPC_BRANCH:         fmt = IMM_B;
      OPC_STORE:          fmt = IMM_S;
      default:            fmt = IMM_I;
    endcase
  end

  decode_imm u_imm (
    .instr_i (instr_i[31:7]),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  // Decode opcode/funct fields into ALU, load/store and branch controls
  always_comb begin
    out_d        = '0;
    out_d.pc     = pc_i;
    out_d.rd     = instr_i[11:7];
    out_d.alu_op = ALU_ADD;
    out_d.cond   = BRANCH_NONE;
    ill_d        = (instr_i[1:0] != 2'b11);
    case (opc)
      OPC_LUI: begin
        out_d.op2       = imm;
        out_d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        out_d.op1       = pc_i;
        out_d.op2       = imm;
        out_d.reg_write = 1'b1;
      end
      OPC_JAL: begin
        out_d.op1       = pc_i;
        out_d.op2       = 32'd4;
        out_d.reg_write = 1'b1;
        out_d.cond      = BRANCH_ALWAYS;
        out_d.target    = pc_i + imm;
      end
      OPC_JALR: begin
        out_d.op1       = pc_i;
        out_d.op2       = 32'd4;
        out_d.reg_write = 1'b1;
        out_d.cond      = BRANCH_ALWAYS;
        out_d.target    = {jalr_sum[31:1], 1'b0};
        if (f3 != 3'b000) ill_d = 1'b1;
      end
      OPC_BRANCH: begin
        out_d.op1    = rs1_data_i;
        out_d.op2    = rs2_data_i;
        out_d.target = pc_i + imm;
        case (f3)
          F3_BEQ:  out_d.cond = BRANCH_EQ;
          F3_BNE:  out_d.cond = BRANCH_NE;
          F3_BLT:  out_d.cond = BRANCH_LT;
          F3_BGE:  out_d.cond = BRANCH_GE;
          F3_BLTU: out_d.cond = BRANCH_LTU;
          F3_BGEU: out_d.cond = BRANCH_GEU;
          default: ill_d = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        out_d.op1       = rs1_data_i;
        out_d.op2       = imm;
        out_d.ls_enable = 1'b1;
        out_d.ls_sel    = f3;
        out_d.reg_write = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill_d = 1'b1;
      end
      OPC_STORE: begin
        out_d.op1       = rs1_data_i;
        out_d.op2       = imm;
        out_d.ls_enable = 1'b1;
        out_d.ls_write  = 1'b1;
        out_d.ls_sel    = f3;
        out_d.ls_wdata  = rs2_data_i;
        if (f3 > 3'b010) ill_d = 1'b1;
      end
      OPC_OP_IMM: begin
        out_d.op1       = rs1_data_i;
        out_d.op2       = imm;
        out_d.alu_op    = f3;
        out_d.reg_write = 1'b1;
        if (f3 == ALU_SLL && f7 != F7_ZERO) ill_d = 1'b1;
        if (f3 == ALU_SR) begin
          if (f7 == F7_ALT)       out_d.shift_arith = 1'b1;
          else if (f7 != F7_ZERO) ill_d = 1'b1;
        end
      end
      OPC_OP: begin
        out_d.op1       = rs1_data_i;
        out_d.op2       = rs2_data_i;
        out_d.alu_op    = f3;
        out_d.reg_write = 1'b1;
        if (f7 == F7_ALT) begin
          if (f3 == ALU_ADD)     out_d.alu_sub     = 1'b1;
          else if (f3 == ALU_SR) out_d.shift_arith = 1'b1;
          else                   ill_d = 1'b1;
        end else if (f7 != F7_ZERO) begin
          ill_d = 1'b1;
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: ill_d = 1'b1;
    endcase
    // Illegal encodings collapse to a NOP that still carries pc and rd
    if (ill_d) begin
      out_d        = '0;
      out_d.pc     = pc_i;
      out_d.rd     = instr_i[11:7];
      out_d.alu_op = ALU_ADD;
      out_d.cond   = BRANCH_NONE;
    end
    if (out_d.rd == 5'd0) out_d.reg_write = 1'b0;
  end

  // Output pipeline register: reset > flush > load > drain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q   <= out_d;
    end else if (output_ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_INSTR_EN
  logic ill_q;

  // Illegal flag travels with the rest of the decoded record
  always_ff @(posedge clk_i) begin
    if (rst_i)                   ill_q <= 1'b0;
    else if (!flush_i && accept) ill_q <= ill_d;
  end

  assign illegal_instr_o = ill_q;
`endif

  assign output_valid_o    = valid_q;
  assign pc_o              = out_q.pc;
  assign alu_operand1_o    = out_q.op1;
  assign alu_operand2_o    = out_q.op2;
  assign alu_op_o          = out_q.alu_op;
  assign alu_sub_o         = out_q.alu_sub;
  assign alu_shift_arith_o = out_q.shift_arith;
  assign reg_write_o       = out_q.reg_write;
  assign reg_addr_o        = out_q.rd;
  assign ls_enable_o       = out_q.ls_enable;
  assign ls_write_o        = out_q.ls_write;
  assign ls_sel_o          = out_q.ls_sel;
  assign ls_write_data_o   = out_q.ls_wdata;
  assign branch_cond_o     = out_q.cond;
  assign branch_target_o   = out_q.target;

endmodule
